// File: rtl/mul_arbiter.sv
// Two-requester arbiter around a shared 8x8 unsigned multiplier with registered results.
// Optional macro MUL_ARB_RR_EN selects round-robin tie-breaking; fixed priority (requester 0) otherwise.
module mul_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] acc0,
  input  logic [7:0] rd0,
  input  logic       req1,
  input  logic [7:0] acc1,
  input  logic [7:0] rd1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] mul_out,
  output logic [7:0] mul_hi,
  output logic       ci_mul,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        winner;
  logic        owner;
  logic [7:0]  op_a_p0, op_b_p0;
  logic [15:0] product_p0;
  logic [7:0]  lo_p1, hi_p1;
  logic        ci_p1;

  function automatic logic [15:0] umul8(input logic [7:0] a, input logic [7:0] b);
    return {8'd0, a} * {8'd0, b};
  endfunction

`ifdef MUL_ARB_RR_EN
  // last == 1 means requester 1 was served most recently; reset value hands the first tie to 0.
  logic last;

  always_comb begin
    winner = (req0 && req1) ? ~last : ~req0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      last <= 1'b1;
    else if (accept)
      last <= winner;
  end
`else
  always_comb begin
    winner = ~req0;
  end
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          accept    = 1'b1;
          state_nxt = MUL;
        end
      end
      MUL:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        owner <= winner;
    end
  end

  // Stage p0: operands captured from the winner only at acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a_p0 <= winner ? acc1 : acc0;
      op_b_p0 <= winner ? rd1  : rd0;
    end
  end

  assign product_p0 = umul8(op_a_p0, op_b_p0);

  // Stage p1: result registers load in MUL and hold until the next MUL.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_p1 <= 8'h00;
      hi_p1 <= 8'h00;
      ci_p1 <= 1'b0;
    end else if (state == MUL) begin
      lo_p1 <= product_p0[7:0];
      hi_p1 <= product_p0[15:8];
      ci_p1 <= |product_p0[15:8];
    end
  end

  assign mul_out = lo_p1;
  assign mul_hi  = hi_p1;
  assign ci_mul  = ci_p1;
  assign busy    = (state != IDLE);
  assign gnt0    = busy & ~owner;
  assign gnt1    = busy & owner;
  assign done0   = (state == DONE) & ~owner;
  assign done1   = (state == DONE) & owner;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: transaction-timeline model plus directed literal checks.
module tb_mul_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] acc0 = 8'd0, rd0 = 8'd0, acc1 = 8'd0, rd1 = 8'd0;
  logic       gnt0, gnt1, done0, done1, ci_mul, busy;
  logic [7:0] mul_out, mul_hi;

  int checks = 0;
  int errors = 0;

  mul_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .acc0(acc0), .rd0(rd0),
    .req1(req1), .acc1(acc1), .rd1(rd1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .mul_out(mul_out), .mul_hi(mul_hi), .ci_mul(ci_mul), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted transaction occupies the unit for two cycles after its
  // accepting edge; the result becomes visible with the done pulse and then persists.
  int          m_left = 0;     // cycles of the current transaction still to show (2 = grant, 1 = done)
  int          m_owner = 0;
  logic [15:0] m_prod = 16'd0;
  logic [15:0] m_res = 16'd0;
  int          m_last = 1;     // requester served most recently; 1 lets requester 0 take the first tie

  always begin
    int w;
    @(negedge clk);
    #3;
    chk("ctrl", {busy, gnt0, gnt1, done0, done1},
        {m_left != 0, m_left != 0 && m_owner == 0, m_left != 0 && m_owner == 1,
         m_left == 1 && m_owner == 0, m_left == 1 && m_owner == 1});
    chk("result", {ci_mul, mul_hi, mul_out}, {m_res[15:8] != 8'd0, m_res});
    if (rst) begin
      m_left = 0;
      m_res  = 16'd0;
      m_last = 1;
    end else if (m_left == 0) begin
      if (req0 || req1) begin
`ifdef MUL_ARB_RR_EN
        if (req0 && req1) w = 1 - m_last;
        else w = req0 ? 0 : 1;
`else
        w = req0 ? 0 : 1;
`endif
        m_owner = w;
        m_last  = w;
        m_prod  = (w == 0) ? acc0 * rd0 : acc1 * rd1;
        m_left  = 2;
      end
    end else if (m_left == 2) begin
      m_res  = m_prod;
      m_left = 1;
    end else begin
      m_left = 0;
    end
  end

  // Directed single operation; unit must be idle with the other requester quiet.
  task automatic run_op(input int who, input logic [7:0] a, input logic [7:0] b,
                        input int lo, input int hi, input int ci);
    @(negedge clk);
    if (who == 0) begin req0 = 1'b1; acc0 = a; rd0 = b; end
    else          begin req1 = 1'b1; acc1 = a; rd1 = b; end
    @(negedge clk);
    chk("grant", who == 0 ? {gnt0, gnt1} : {gnt1, gnt0}, 2'b10);
    chk("busy_mul", busy, 1);
    if (who == 0) begin acc0 = 8'd100; rd0 = 8'd77; end
    else          begin acc1 = 8'd100; rd1 = 8'd77; end
    @(negedge clk);
    chk("done", who == 0 ? {done0, done1} : {done1, done0}, 2'b10);
    chk("lo", mul_out, lo);
    chk("hi", mul_hi, hi);
    chk("ci", ci_mul, ci);
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    @(negedge clk);
    chk("idle_after", {busy, gnt0, gnt1, done0, done1}, 0);
    chk("hold_lo", mul_out, lo);
  endtask

  initial begin
    int d0, d1;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {busy, gnt0, gnt1, done0, done1}, 0);
    chk("rst_res", {ci_mul, mul_hi, mul_out}, 0);
    rst = 1'b0;

    run_op(0, 8'd12, 8'd10, 8'h78, 8'h00, 0);
    run_op(1, 8'd255, 8'd255, 8'h01, 8'hFE, 1);
    run_op(0, 8'd2, 8'd3, 8'h06, 8'h00, 0);

    // Reset during MUL aborts the operation.
    @(negedge clk);
    req0 = 1'b1; acc0 = 8'd9; rd0 = 8'd9;
    @(negedge clk);
    chk("abort_gnt", gnt0, 1);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    chk("abort_ctrl", {busy, gnt0, done0}, 0);
    chk("abort_res", {ci_mul, mul_out}, 0);
    rst = 1'b0;
    run_op(0, 8'd7, 8'd9, 8'h3F, 8'h00, 0);

    // Tie from reset: requester 0 first, requester 1 accepted three cycles later.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; acc0 = 8'd3; rd0 = 8'd4;
    req1 = 1'b1; acc1 = 8'd5; rd1 = 8'd6;
    @(negedge clk);
    chk("tie_gnt0", {gnt0, gnt1}, 2'b10);
    @(negedge clk);
    chk("tie_done0", {done0, done1, mul_out}, {2'b10, 8'h0C});
    req0 = 1'b0;
    @(negedge clk);
    chk("tie_gap", busy, 0);
    @(negedge clk);
    chk("tie_gnt1", {gnt0, gnt1}, 2'b01);
    @(negedge clk);
    chk("tie_done1", {done0, done1, mul_out}, {2'b01, 8'h1E});
    req1 = 1'b0;
    @(negedge clk);

    // Both held continuously for 12 cycles.
    d0 = 0; d1 = 0;
    req0 = 1'b1; req1 = 1'b1;
    repeat (12) begin
      @(negedge clk);
      d0 += int'(done0);
      d1 += int'(done1);
    end
    req0 = 1'b0; req1 = 1'b0;
`ifdef MUL_ARB_RR_EN
    chk("hold_rr_d0", d0, 2);
    chk("hold_rr_d1", d1, 2);
`else
    chk("hold_fixed_d0", d0, 4);
    chk("hold_fixed_d1", d1, 0);
`endif
    repeat (3) @(negedge clk);

    // Randomized traffic checked by the model.
    repeat (600) begin
      @(negedge clk);
      rst = ($urandom_range(0, 63) == 0);
      if (done0) req0 = 1'b0;
      else if (!req0) begin
        req0 = ($urandom_range(0, 1) == 1);
        acc0 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        rd0  = 8'($urandom);
      end else if (gnt0) begin
        acc0 = 8'($urandom); rd0 = 8'($urandom);
      end
      if (done1) req1 = 1'b0;
      else if (!req1) begin
        req1 = ($urandom_range(0, 1) == 1);
        acc1 = 8'($urandom);
        rd1  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      end else if (gnt1) begin
        acc1 = 8'($urandom); rd1 = 8'($urandom);
      end
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(negedge clk);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Shares a single 8x8 unsigned multiply datapath between two requesters (e.g. the ALU sequencer and the address/index unit). Accepts requests with a level handshake and arbitrates simultaneous requests. Latches operands, runs one multiply, and returns a registered 8-bit result with carry/overflow flag and high byte, signalled by a one-cycle done pulse to the winning requester. Sits between the requesting units and the combinational multiplier, which it instantiates internally.

## Interface
- No parameters; datapath width fixed at 8 bits.
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req0  input  1  requester 0 multiply request (level)
- acc0, rd0  input  8 each  requester 0 operands
- req1  input  1  requester 1 multiply request (level)
- acc1, rd1  input  8 each  requester 1 operands
- gnt0, gnt1  output  1 each  owner indication, high while that requester's operation is in flight
- done0, done1  output  1 each  one-cycle result-valid pulse to owner
- mul_out  output  8  product[7:0], registered
- mul_hi  output  8  product[15:8], registered
- ci_mul  output  1  registered, = |product[15:8] (result did not fit 8 bits)
- busy  output  1  high whenever state != IDLE

## Operation
- Three-state FSM: IDLE, MUL, DONE.
- IDLE:
  - if no req, stay.
  - Else pick winner, capture its operands into op_a/op_b, record owner, assert that gnt on entering MUL, go MUL.
- MUL:
  - product = op_a * op_b, full 16 bits, unsigned, zero-extended.
  - Register mul_out, mul_hi, ci_mul; go DONE.
- DONE:
  - Assert done of owner for exactly this cycle; gnt stays high; go IDLE.
- Leaving DONE: gnt cleared.
- Result registers hold their value until the next MUL cycle overwrites them.
- Operand inputs are sampled only in IDLE at acceptance; changes afterwards are ignored.
- Requesters drop req in the cycle done is high. A req still high when the FSM re-enters IDLE is a new request and is re-issued.
- Both requests high in IDLE: winner per Configuration. Loser keeps req high and is served after DONE.
- Reset:
  - state IDLE; gnt0, gnt1, done0, done1, busy = 0.
  - mul_out, mul_hi = 0x00; ci_mul = 0.
  - round-robin pointer favours requester 0.
- Reset asserted in MUL or DONE aborts the operation. No done pulse is issued and result registers clear.
- Requests arriving while busy are not acknowledged; they wait (no queueing beyond the held level).

## Timing
- Edge k: req sampled in IDLE, operands latched.
- Cycle k..k+1: gnt high and busy high (MUL state).
- Edge k+1: result registered.
- Cycle k+1..k+2: DONE state. done pulses; mul_out, mul_hi, ci_mul are valid and remain stable after.
- Edge k+2: back to IDLE; gnt and busy fall.
- Latency: done visible 2 cycles after the accepting edge.
- Throughput: one operation per 3 cycles under back-to-back requests.
- done0 and done1 are never high together; gnt0 and gnt1 are never high together.

## Configuration
- MUL_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit pointer records the last-served requester and updates at acceptance.
  - On a tie, the requester not served last wins.
  - A lone request always wins.
- MUL_ARB_RR_EN undefined: fixed priority; requester 0 always wins ties. The pointer logic is absent.

## Test plan
- Single op: req0=1, acc0=12, rd0=10 -> gnt0 high 2 cycles; done0 pulse 2 cycles after acceptance; mul_out=0x78, mul_hi=0x00, ci_mul=0; gnt1, done1 stay 0.
- Overflow: req1=1, acc1=255, rd1=255 -> done1 pulse; mul_out=0x01, mul_hi=0xFE, ci_mul=1.
- Tie with MUL_ARB_RR_EN: req0 and req1 high from reset, held until own done.
  - acc0=3, rd0=4; acc1=5, rd1=6.
  - Required: done0 with mul_out=0x0C first, then done1 with mul_out=0x1E.
  - Second acceptance 3 cycles after the first.
- Fixed priority (macro undefined): req0 held high continuously, req1 high -> requester 0 served repeatedly every 3 cycles; done1 never asserts while req0 stays high.
- Operand change mid-op: accept acc0=2, rd0=3, then change acc0 to 100 in MUL -> mul_out=0x06.
- Reset mid-op: assert rst in MUL cycle -> no done pulse; the next cycle shows busy=0, gnt0=0, mul_out=0x00, ci_mul=0. A following req0 with 7x9 gives mul_out=0x3F.
